// File: rtl/limber_gnrl_ramreq_if.sv
// rtl/limber_gnrl_ramreq_if.sv - command, response and RAM-port bundle for limber_gnrl_ramreq
interface limber_gnrl_ramreq_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready, ram_dout,
    output cmd_ready, rsp_valid, rsp_rdata, ram_cs, ram_we, ram_addr, ram_din
  );

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready, ram_dout,
    input  cmd_ready, rsp_valid, rsp_rdata, ram_cs, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/limber_gnrl_ramreq.sv
// rtl/limber_gnrl_ramreq.sv - valid/ready front end for a fixed-latency single-port RAM
// Responses come back in order through a CAP-deep FIFO; credit counting makes overflow impossible.
module limber_gnrl_ramreq #(
  parameter int DW  = 32,
  parameter int AW  = 8,
  parameter int DLY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  limber_gnrl_ramreq_if.slave   bus
);
  localparam int CAP = DLY + 2;
  localparam int CW  = $clog2(CAP + 1);
  localparam int PW  = (CAP > 1) ? $clog2(CAP) : 1;

  logic           w_cmd_hs;
  logic           w_rsp_hs;
  logic           w_push;
  logic [DW-1:0]  w_push_data;
  logic [DLY-1:0] r_pv;
  logic [DLY-1:0] r_pr;
  logic [CW-1:0]  r_outstd;
  logic [CW-1:0]  r_fcnt;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [DW-1:0]  r_mem [CAP];

  assign w_cmd_hs      = bus.cmd_valid & bus.cmd_ready;
  assign bus.cmd_ready = (r_outstd < CW'(CAP));
  assign bus.ram_cs    = w_cmd_hs;
  assign bus.ram_we    = w_cmd_hs & ~bus.cmd_read;
  assign bus.ram_addr  = bus.cmd_addr;
  assign bus.ram_din   = bus.cmd_wdata;

  assign w_push      = r_pv[DLY-1];
  assign w_push_data = r_pr[DLY-1] ? bus.ram_dout : '0;

  assign bus.rsp_valid = (r_fcnt != '0);
  assign bus.rsp_rdata = bus.rsp_valid ? r_mem[r_rptr] : '0;
  assign w_rsp_hs      = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      r_pr <= '0;
    end else begin
      r_pv[0] <= w_cmd_hs;
      r_pr[0] <= bus.cmd_read;
      for (int k = 1; k < DLY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pr[k] <= r_pr[k-1];
      end
    end
  end

  // Credits cover both the pipeline and the FIFO, so a push always has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstd <= '0;
    end else begin
      case ({w_cmd_hs, w_rsp_hs})
        2'b10:   r_outstd <= r_outstd + CW'(1);
        2'b01:   r_outstd <= r_outstd - CW'(1);
        default: r_outstd <= r_outstd;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      case ({w_push, w_rsp_hs})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(CAP - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_rsp_hs) begin
        r_rptr <= (r_rptr == PW'(CAP - 1)) ? '0 : r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end
endmodule
